alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- WIDTH-bit multi-cycle ALU, the parametrised successor to the 1-bit ALU slice.
- Single-cycle ops: AND, OR, XOR, ADD, SUB, SLT. Multi-cycle op: unsigned shift-add MUL.
- Start/Busy/Done handshake. All outputs are registered.
- Sits between the register file read stage and write-back. The control unit drives Op and the operands and waits for Done.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, width of the MUL iteration counter.

Ports:
- Clock  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  request; sampled only in IDLE.
- Op  in  3  000 AND, 001 SLT, 010 OR, 011 XOR, 100 ADD, 101 SUB, 110 MUL, 111 reserved.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Result  out  WIDTH  result; low half for MUL.
- ResultHi  out  WIDTH  high half of the MUL product; 0 for all other ops.
- Zero  out  1  Result==0; for MUL, the full 2*WIDTH product==0.
- CarryOut  out  1  adder carry-out for ADD/SUB; 0 otherwise.
- Overflow  out  1  signed overflow for ADD/SUB; ResultHi!=0 for MUL; 0 otherwise.
- Busy  out  1  high while a MUL is iterating.
- Done  out  1  one-cycle pulse when outputs are updated.

Behaviour:
- Reset (synchronous, active-high): state=IDLE. Result, ResultHi, Zero, CarryOut, Overflow, Busy and Done are all 0. The counter and operand registers are cleared.
- Reset asserted mid-operation aborts the operation. No Done is produced. The next Start after Reset deasserts is processed normally.
- States: IDLE, MUL. There is no separate DONE state; Done is a registered pulse.
- IDLE with Start=1 and Op!=110:
  - The combinational result is computed from A/B/Op in the Start cycle and registered at that edge.
  - Done=1 in the next cycle (latency 1). Back-to-back Starts give Done every cycle.
  - State stays IDLE.
- IDLE with Start=1 and Op==110:
  - Latch A into a multiplicand register zero-extended to 2*WIDTH, B into a multiplier register, clear the accumulator, set count=0.
  - Go to MUL; Busy=1 from the next cycle.
- MUL, each cycle:
  - If the multiplier LSB is 1, the accumulator adds the multiplicand.
  - The multiplicand shifts left by 1, the multiplier shifts right by 1, and count increments.
  - After the WIDTH-th iteration: register {ResultHi,Result}=accumulator and set the flags. Busy=0 and Done=1 in the same cycle. Return to IDLE.
  - MUL latency: Done is asserted exactly WIDTH+1 cycles after the Start cycle. Busy is high for WIDTH cycles.
- Start while Busy is ignored: no queueing, and Op/A/B changes have no effect on the MUL in flight.
- Arithmetic:
  - ADD: {CarryOut,Result}=A+B.
  - SUB: A+~B+1, so CarryOut=1 means no borrow.
  - Overflow for ADD/SUB = (sign of A == sign of the effective B) && (sign of Result != sign of A).
  - SLT: Result = {WIDTH-1 zeros, sub_sign XOR sub_overflow}. This is a signed compare and is correct at the extremes. CarryOut and Overflow are 0 for SLT.
  - Wrap-around: ADD/SUB results are modulo 2^WIDTH.
- Op 111: Result=0, Zero=1, Done after 1 cycle. It is not an error.
- Between Done pulses, the outputs hold their last values. Done is low except for the single completion cycle.

Decomposition:
- Shared header/package alu_defs: the opcode constants (OP_AND..OP_MUL, OP_RSV) and the state encodings (S_IDLE, S_MUL). The decoder and control unit reuse them.
- One sub-module: alu_comb_nbit, parametrised WIDTH. It is purely combinational and covers AND/OR/XOR/ADD/SUB/SLT with carry and overflow. alu_seq instantiates it and owns all sequential logic (registers, FSM, MUL datapath).

Test Plan (WIDTH=16):
- ADD A=0x7FFF, B=0x0001, Start for 1 cycle -> next cycle Done=1, Result=0x8000, Overflow=1, CarryOut=0, Zero=0.
- SUB A=0x0005, B=0x0005 -> Result=0x0000, Zero=1, CarryOut=1, Overflow=0. Then SUB 0x0000-0x0001 -> Result=0xFFFF, CarryOut=0.
- SLT A=0x8000, B=0x7FFF -> Result=0x0001. SLT A=0x0001, B=0xFFFF -> Result=0x0000. Op 111 -> Result=0, Zero=1.
- MUL A=0x0123, B=0x0010 -> Busy high for 16 cycles, Done exactly 17 cycles after Start, Result=0x1230, ResultHi=0, Overflow=0. Re-pulse Start with Op=ADD during Busy -> ignored, result unchanged.
- MUL A=0xFFFF, B=0xFFFF -> ResultHi=0xFFFE, Result=0x0001, Overflow=1. Back-to-back AND 0xF0F0&0x0FF0 and OR on consecutive cycles -> Done on two consecutive cycles with Result=0x00F0, then the OR value.
- Reset asserted on the 5th MUL cycle -> the next cycle shows all outputs 0, Busy=0, and no Done. A subsequent ADD 0x0002+0x0003 -> Result=0x0005 with latency 1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state encodings for the ALU, decoder and control unit.
package alu_defs;

   localparam int unsigned OP_W    = 3;
   localparam int unsigned STATE_W = 1;

   localparam logic [OP_W-1:0] OP_AND = 3'b000;
   localparam logic [OP_W-1:0] OP_SLT = 3'b001;
   localparam logic [OP_W-1:0] OP_OR  = 3'b010;
   localparam logic [OP_W-1:0] OP_XOR = 3'b011;
   localparam logic [OP_W-1:0] OP_ADD = 3'b100;
   localparam logic [OP_W-1:0] OP_SUB = 3'b101;
   localparam logic [OP_W-1:0] OP_MUL = 3'b110;
   localparam logic [OP_W-1:0] OP_RSV = 3'b111;

   localparam logic [STATE_W-1:0] S_IDLE = 1'b0;
   localparam logic [STATE_W-1:0] S_MUL  = 1'b1;

endpackage

// File: rtl/alu_comb_nbit.sv
// Combinational N-bit ALU slice: logic ops, ADD/SUB with carry/overflow, signed SLT.
module alu_comb_nbit
   import alu_defs::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned SW = WIDTH + 1;

   logic             sub_op;
   logic [WIDTH-1:0] b_eff;
   logic [SW-1:0]    sum;
   logic             sum_ovf;
   logic [WIDTH-1:0] diff;
   logic             diff_ovf;

   // Shared adder: SUB is A + ~B + 1, so carry-out high means no borrow.
   assign sub_op  = (op == OP_SUB);
   assign b_eff   = sub_op ? ~b : b;
   assign sum     = {1'b0, a} + {1'b0, b_eff} + SW'(sub_op);
   assign sum_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

   // Dedicated subtractor for SLT so the compare is independent of op decode.
   assign diff     = a + ~b + WIDTH'(1);
   assign diff_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      result    = '0;
      carry_out = 1'b0;
      overflow  = 1'b0;
      case (op)
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_ADD, OP_SUB: begin
            result    = sum[WIDTH-1:0];
            carry_out = sum[WIDTH];
            overflow  = sum_ovf;
         end
         OP_SLT: result = WIDTH'(diff[WIDTH-1] ^ diff_ovf);
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned shift-add MUL.
module alu_seq
   import alu_defs::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             carry_out,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int unsigned PW = 2 * WIDTH;

   logic [STATE_W-1:0] state, state_n;
   logic [PW-1:0]      mcand, mcand_n;
   logic [PW-1:0]      acc, acc_n, acc_add;
   logic [WIDTH-1:0]   mplier, mplier_n;
   logic [CNT_W-1:0]   count, count_n;
   logic [WIDTH-1:0]   result_n, result_hi_n;
   logic               zero_n, carry_out_n, overflow_n, busy_n, done_n;

   logic [WIDTH-1:0]   comb_result;
   logic               comb_carry, comb_ovf;

   alu_comb_nbit #(.WIDTH(WIDTH)) u_comb (
      .op        (op),
      .a         (a),
      .b         (b),
      .result    (comb_result),
      .carry_out (comb_carry),
      .overflow  (comb_ovf)
   );

   assign acc_add = mplier[0] ? (acc + mcand) : acc;

   // Next-state and next-output logic; outputs hold unless a completion occurs.
   always_comb begin
      state_n     = state;
      mcand_n     = mcand;
      acc_n       = acc;
      mplier_n    = mplier;
      count_n     = count;
      result_n    = result;
      result_hi_n = result_hi;
      zero_n      = zero;
      carry_out_n = carry_out;
      overflow_n  = overflow;
      busy_n      = busy;
      done_n      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (op == OP_MUL) begin
                  mcand_n  = PW'(a);
                  mplier_n = b;
                  acc_n    = '0;
                  count_n  = '0;
                  busy_n   = 1'b1;
                  state_n  = S_MUL;
               end else begin
                  result_n    = comb_result;
                  result_hi_n = '0;
                  zero_n      = (comb_result == '0);
                  carry_out_n = comb_carry;
                  overflow_n  = comb_ovf;
                  done_n      = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_n    = acc_add;
            mcand_n  = mcand << 1;
            mplier_n = mplier >> 1;
            count_n  = count + CNT_W'(1);
            if (count == CNT_W'(WIDTH - 1)) begin
               {result_hi_n, result_n} = acc_add;
               zero_n      = (acc_add == '0);
               carry_out_n = 1'b0;
               overflow_n  = (acc_add[PW-1:WIDTH] != '0);
               busy_n      = 1'b0;
               done_n      = 1'b1;
               state_n     = S_IDLE;
            end
         end
         default: begin
            busy_n  = 1'b0;
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         mcand     <= '0;
         acc       <= '0;
         mplier    <= '0;
         count     <= '0;
         result    <= '0;
         result_hi <= '0;
         zero      <= 1'b0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         mcand     <= mcand_n;
         acc       <= acc_n;
         mplier    <= mplier_n;
         count     <= count_n;
         result    <= result_n;
         result_hi <= result_hi_n;
         zero      <= zero_n;
         carry_out <= carry_out_n;
         overflow  <= overflow_n;
         busy      <= busy_n;
         done      <= done_n;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16).
module tb_alu_seq;
   import alu_defs::*;

   localparam int unsigned WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [OP_W-1:0]  op;
   logic [WIDTH-1:0] a, b;
   logic [WIDTH-1:0] result, result_hi;
   logic             zero, carry_out, overflow, busy, done;

   int tests = 0;
   int fails = 0;
   int lat, nbusy, ndone;
   bit got;

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .result    (result),
      .result_hi (result_hi),
      .zero      (zero),
      .carry_out (carry_out),
      .overflow  (overflow),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Launch a MUL and count cycles until done; optionally poke an ADD start while busy.
   task automatic run_mul(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                          input bit poke, output int l, output int nb, output bit g);
      @(negedge clk);
      start = 1'b1; op = OP_MUL; a = ma; b = mb;
      l = 0; nb = 0; g = 1'b0;
      for (int i = 0; i < 40 && !g; i++) begin
         @(negedge clk);
         l++;
         if (busy) nb++;
         if (done) g = 1'b1;
         start = poke && (l == 3);
         if (poke && l == 3) begin
            op = OP_ADD; a = 16'h1111; b = 16'h2222;
         end
      end
      start = 1'b0;
   endtask

   task automatic issue(input logic [OP_W-1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = OP_AND; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("rst_result", 32'(result), 32'h0);
      chk("rst_flags", {27'd0, zero, carry_out, overflow, busy, done}, 32'h0);
      rst = 1'b0;

      issue(OP_ADD, 16'h7FFF, 16'h0001);
      chk("add_done", 32'(done), 32'h1);
      chk("add_result", 32'(result), 32'h8000);
      chk("add_flags", {29'd0, zero, carry_out, overflow}, 32'h1);
      @(negedge clk);
      chk("add_done_pulse", 32'(done), 32'h0);
      chk("add_hold", 32'(result), 32'h8000);

      issue(OP_SUB, 16'h0005, 16'h0005);
      chk("sub_eq_result", 32'(result), 32'h0);
      chk("sub_eq_flags", {29'd0, zero, carry_out, overflow}, 32'h6);
      issue(OP_SUB, 16'h0000, 16'h0001);
      chk("sub_borrow_result", 32'(result), 32'hFFFF);
      chk("sub_borrow_flags", {29'd0, zero, carry_out, overflow}, 32'h0);

      issue(OP_SLT, 16'h8000, 16'h7FFF);
      chk("slt_neg_result", 32'(result), 32'h1);
      chk("slt_neg_flags", {29'd0, zero, carry_out, overflow}, 32'h0);
      issue(OP_SLT, 16'h0001, 16'hFFFF);
      chk("slt_pos_result", 32'(result), 32'h0);
      chk("slt_pos_zero", 32'(zero), 32'h1);

      issue(OP_ADD, 16'h1234, 16'h0001);
      issue(OP_RSV, 16'hAAAA, 16'h5555);
      chk("rsv_done", 32'(done), 32'h1);
      chk("rsv_result", 32'(result), 32'h0);
      chk("rsv_zero", 32'(zero), 32'h1);

      run_mul(16'h0123, 16'h0010, 1'b1, lat, nbusy, got);
      chk("mul1_done_seen", 32'(got), 32'h1);
      chk("mul1_latency", 32'(lat), 32'd17);
      chk("mul1_busy_cycles", 32'(nbusy), 32'd16);
      chk("mul1_product", {result_hi, result}, 32'h0000_1230);
      chk("mul1_flags", {28'd0, zero, carry_out, overflow, busy}, 32'h0);
      @(negedge clk);
      chk("mul1_no_extra_done", 32'(done), 32'h0);
      chk("mul1_hold", 32'(result), 32'h1230);

      run_mul(16'hFFFF, 16'hFFFF, 1'b0, lat, nbusy, got);
      chk("mul2_latency", 32'(lat), 32'd17);
      chk("mul2_product", {result_hi, result}, 32'hFFFE_0001);
      chk("mul2_flags", {29'd0, zero, carry_out, overflow}, 32'h1);

      @(negedge clk);
      start = 1'b1; op = OP_AND; a = 16'hF0F0; b = 16'h0FF0;
      @(negedge clk);
      chk("and_done", 32'(done), 32'h1);
      chk("and_result", {result_hi, result}, 32'h0000_00F0);
      op = OP_OR;
      @(negedge clk);
      start = 1'b0;
      chk("or_done", 32'(done), 32'h1);
      chk("or_result", 32'(result), 32'hFFF0);

      // Reset on the 5th MUL cycle aborts without a done.
      @(negedge clk);
      start = 1'b1; op = OP_MUL; a = 16'h00FF; b = 16'h00FF;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_before", 32'(busy), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_outputs", {result_hi, result}, 32'h0);
      chk("abort_flags", {27'd0, zero, carry_out, overflow, busy, done}, 32'h0);
      ndone = 0;
      repeat (20) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      chk("abort_no_done", 32'(ndone), 32'd0);

      issue(OP_ADD, 16'h0002, 16'h0003);
      chk("post_abort_done", 32'(done), 32'h1);
      chk("post_abort_result", 32'(result), 32'h0005);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
